// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO with AXI-Stream handshakes,
// level flags, synchronous flush and a clearable high-water mark.
module axis_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET_N,
    input  logic                    FLUSH,
    input  logic                    HWM_CLR,
    input  logic [DATA_WIDTH-1:0]   S_TDATA,
    input  logic                    S_TVALID,
    output logic                    S_TREADY,
    output logic [DATA_WIDTH-1:0]   M_TDATA,
    output logic                    M_TVALID,
    input  logic                    M_TREADY,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]  HIGH_WATER
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count_nxt;
    logic full, empty, push, pop;

    // Extra pointer MSB distinguishes full from empty so every slot is usable
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign S_TREADY     = !full;
    assign M_TVALID     = !empty;
    assign push         = S_TVALID && !full;
    assign pop          = M_TREADY && !empty;
    assign M_TDATA      = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign ALMOST_FULL  = COUNT >= AF;
    assign ALMOST_EMPTY = COUNT <= AE;

    always_comb begin
        count_nxt = FLUSH ? '0 :
                    (push && !pop) ? COUNT + 1'b1 :
                    (pop && !push) ? COUNT - 1'b1 : COUNT;
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            COUNT      <= '0;
            HIGH_WATER <= '0;
        end else begin
            wr_ptr     <= FLUSH ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= FLUSH ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            COUNT      <= count_nxt;
            HIGH_WATER <= (HWM_CLR || count_nxt > HIGH_WATER) ? count_nxt : HIGH_WATER;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push && !FLUSH)
            mem[wr_ptr[AW-1:0]] <= S_TDATA;
    end
endmodule
